// File: rtl/axil_io_pkg.sv
// Shared constants for the AXI4-Lite LED / 7-segment / IRQ peripheral.
// Register offsets, response codes and the hex-to-segment table.
package axil_io_pkg;

   localparam logic [4:0] OFF_LED      = 5'h00;
   localparam logic [4:0] OFF_SEG      = 5'h04;
   localparam logic [4:0] OFF_IRQ_EN   = 5'h08;
   localparam logic [4:0] OFF_IRQ_STAT = 5'h0C;
   localparam logic [4:0] OFF_ID       = 5'h10;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_t;

   // Segments {g,f,e,d,c,b,a}, active-low; entry 15 first.
   localparam logic [15:0][6:0] SEG_LUT = {
      7'h0E, 7'h06, 7'h21, 7'h46,
      7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19,
      7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/axil_io_periph_seg7_scan.sv
// Multiplexed 4-digit 7-segment scanner: prescaler, digit index, decode.
// Anode and cathode are latched together at each slot start.
module seg7_scan
   import axil_io_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [15:0] seg_i,
   output logic [3:0]  anode_o,
   output logic [6:0]  cathode_o
);

   localparam int CW = $clog2(REFRESH_DIV);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    cat_q, cat_d;
   logic          wrap;

   always_comb begin
      wrap  = (cnt_q == CW'(REFRESH_DIV - 1));
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      an_d  = an_q;
      cat_d = cat_q;
      if (wrap) begin
         idx_d = idx_q + 2'd1;
         an_d  = ~(4'b0001 << idx_d);
         cat_d = SEG_LUT[seg_i[{idx_d, 2'b00} +: 4]];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         idx_q <= 2'd0;
         an_q  <= 4'hF;
         cat_q <= 7'h7F;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         an_q  <= an_d;
         cat_q <= cat_d;
      end
   end

   assign anode_o   = an_q;
   assign cathode_o = cat_q;

endmodule

// File: rtl/axil_io_periph.sv
// AXI4-Lite slave: LED, 7-segment display and edge-triggered IRQ registers.
// Define AXIL_IO_IRQ_SYNC_EN to add a 2-flop synchronizer on ext_irq_in.
module axil_io_periph
   import axil_io_pkg::*;
#(
   parameter int          ADDR_WIDTH  = 32,
   parameter int          DATA_WIDTH  = 32,
   parameter int          REFRESH_DIV = 50000,
   parameter logic [31:0] ID_VALUE    = 32'hA110_0001
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   input  logic [ADDR_WIDTH-1:0] AWADDR,
   input  logic [2:0]            AWPROT,
   input  logic                  AWVALID,
   output logic                  AWREADY,
   input  logic [DATA_WIDTH-1:0] WDATA,
   input  logic [3:0]            WSTRB,
   input  logic                  WVALID,
   output logic                  WREADY,
   output logic [1:0]            BRESP,
   output logic                  BVALID,
   input  logic                  BREADY,
   input  logic [ADDR_WIDTH-1:0] ARADDR,
   input  logic [2:0]            ARPROT,
   input  logic                  ARVALID,
   output logic                  ARREADY,
   output logic [DATA_WIDTH-1:0] RDATA,
   output logic [1:0]            RRESP,
   output logic                  RVALID,
   input  logic                  RREADY,
   input  logic                  ext_irq_in,
   output logic [3:0]            leds,
   output logic [6:0]            seg_cathode,
   output logic [3:0]            seg_anode,
   output logic                  irq_out
);

   logic                  rdy_q;
   logic                  aw_full_q, w_full_q;
   logic [ADDR_WIDTH-1:0] awaddr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [3:0]            wstrb_q;
   logic                  bvalid_q, rvalid_q;
   resp_t                 bresp_q, rresp_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [3:0]            led_q, led_d;
   logic [15:0]           seg_q, seg_d;
   logic                  en_q, en_d;
   logic                  stat_q, stat_d;
   logic                  irq_q;
   logic                  wr_go, wr_clr, rise;
   resp_t                 wr_resp, rd_resp;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  aw_hs, w_hs, b_hs, ar_hs;
   logic                  unused_ok;

   function automatic logic mapped(input logic [ADDR_WIDTH-1:0] a);
      return (a[ADDR_WIDTH-1:5] == '0) && (a[4:2] <= 3'd4);
   endfunction

   assign AWREADY = rdy_q & ~aw_full_q;
   assign WREADY  = rdy_q & ~w_full_q;
   assign ARREADY = rdy_q & ~rvalid_q;
   assign aw_hs   = AWVALID & AWREADY;
   assign w_hs    = WVALID & WREADY;
   assign b_hs    = bvalid_q & BREADY;
   assign ar_hs   = ARVALID & ARREADY;
   assign wr_go   = aw_full_q & w_full_q & ~bvalid_q;

   always_comb begin
      led_d   = led_q;
      seg_d   = seg_q;
      en_d    = en_q;
      wr_clr  = 1'b0;
      wr_resp = RESP_OKAY;
      if (wr_go) begin
         if (!mapped(awaddr_q) || {awaddr_q[4:2], 2'b00} == OFF_ID) begin
            wr_resp = RESP_SLVERR;
         end else begin
            unique case ({awaddr_q[4:2], 2'b00})
               OFF_LED:      if (wstrb_q[0]) led_d = wdata_q[3:0];
               OFF_SEG: begin
                  if (wstrb_q[0]) seg_d[7:0]  = wdata_q[7:0];
                  if (wstrb_q[1]) seg_d[15:8] = wdata_q[15:8];
               end
               OFF_IRQ_EN:   if (wstrb_q[0]) en_d = wdata_q[0];
               OFF_IRQ_STAT: wr_clr = wstrb_q[0] & wdata_q[0];
               default: ;
            endcase
         end
      end
      // A new edge outranks a simultaneous W1C.
      stat_d = (stat_q & ~wr_clr) | rise;
   end

   always_comb begin
      rd_data = '0;
      rd_resp = RESP_OKAY;
      if (!mapped(ARADDR)) begin
         rd_resp = RESP_SLVERR;
      end else begin
         unique case ({ARADDR[4:2], 2'b00})
            OFF_LED:      rd_data[3:0]  = led_q;
            OFF_SEG:      rd_data[15:0] = seg_q;
            OFF_IRQ_EN:   rd_data[0]    = en_q;
            OFF_IRQ_STAT: rd_data[0]    = stat_q;
            OFF_ID:       rd_data       = DATA_WIDTH'(ID_VALUE);
            default: ;
         endcase
      end
   end

`ifdef AXIL_IO_IRQ_SYNC_EN
   logic [1:0] sync_q;
   logic       prev_q;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         sync_q <= 2'b00;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], ext_irq_in};
         prev_q <= sync_q[1];
      end
   end

   assign rise = sync_q[1] & ~prev_q;
`else
   logic prev_q;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) prev_q <= 1'b0;
      else          prev_q <= ext_irq_in;
   end

   assign rise = ext_irq_in & ~prev_q;
`endif

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         rdy_q     <= 1'b0;
         aw_full_q <= 1'b0;
         w_full_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= 4'h0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
         led_q     <= 4'h0;
         seg_q     <= 16'h0;
         en_q      <= 1'b0;
         stat_q    <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         if (aw_hs) begin
            aw_full_q <= 1'b1;
            awaddr_q  <= AWADDR;
         end
         if (w_hs) begin
            w_full_q <= 1'b1;
            wdata_q  <= WDATA;
            wstrb_q  <= WSTRB;
         end
         // Holding registers stay full until the response is taken.
         if (b_hs) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bvalid_q  <= 1'b0;
         end
         if (wr_go) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_resp;
         end
         if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
            rresp_q  <= rd_resp;
         end else if (rvalid_q && RREADY) begin
            rvalid_q <= 1'b0;
         end
         led_q  <= led_d;
         seg_q  <= seg_d;
         en_q   <= en_d;
         stat_q <= stat_d;
         irq_q  <= en_q & stat_q;
      end
   end

   assign BVALID  = bvalid_q;
   assign BRESP   = bresp_q;
   assign RVALID  = rvalid_q;
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;
   assign leds    = led_q;
   assign irq_out = irq_q;

   seg7_scan #(
      .REFRESH_DIV(REFRESH_DIV)
   ) u_scan (
      .clk_i    (ACLK),
      .rst_ni   (ARESETn),
      .seg_i    (seg_q),
      .anode_o  (seg_anode),
      .cathode_o(seg_cathode)
   );

   assign unused_ok = ^{AWPROT, ARPROT, awaddr_q[1:0], ARADDR[1:0],
                        wdata_q[DATA_WIDTH-1:16], wstrb_q[3:2]};

endmodule

// File: tb/tb_axil_io_periph.sv
// Directed self-checking bench for axil_io_periph (REFRESH_DIV = 4).
module tb_axil_io_periph;

   localparam logic [31:0] IDV = 32'hA110_0001;
`ifdef AXIL_IO_IRQ_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   logic [31:0] AWADDR = '0;
   logic [2:0]  AWPROT = '0;
   logic        AWVALID = 1'b0;
   logic        AWREADY;
   logic [31:0] WDATA = '0;
   logic [3:0]  WSTRB = '0;
   logic        WVALID = 1'b0;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY = 1'b0;
   logic [31:0] ARADDR = '0;
   logic [2:0]  ARPROT = '0;
   logic        ARVALID = 1'b0;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY = 1'b0;
   logic        ext_irq_in = 1'b0;
   logic [3:0]  leds;
   logic [6:0]  seg_cathode;
   logic [3:0]  seg_anode;
   logic        irq_out;

   int n_cmp = 0;
   int n_err = 0;

   always #5 ACLK = ~ACLK;

   axil_io_periph #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .REFRESH_DIV(4), .ID_VALUE(IDV)
   ) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
      .ext_irq_in(ext_irq_in), .leds(leds), .seg_cathode(seg_cathode),
      .seg_anode(seg_anode), .irq_out(irq_out)
   );

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp,
                            output logic ok);
      logic aw, w;
      ok = 1'b0;
      resp = 2'bxx;
      AWADDR = a; AWVALID = 1'b1;
      WDATA = d; WSTRB = s; WVALID = 1'b1;
      BREADY = 1'b1;
      for (int i = 0; i < 20 && (AWVALID || WVALID); i++) begin
         @(negedge ACLK);
         aw = AWVALID && AWREADY;
         w  = WVALID && WREADY;
         @(posedge ACLK); #1;
         if (aw) AWVALID = 1'b0;
         if (w)  WVALID = 1'b0;
      end
      for (int i = 0; i < 20 && !ok && !AWVALID && !WVALID; i++) begin
         @(negedge ACLK);
         if (BVALID) begin
            resp = BRESP;
            ok = 1'b1;
         end
         @(posedge ACLK); #1;
      end
      AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output logic ok);
      logic hs;
      ok = 1'b0;
      hs = 1'b0;
      d = 'x; resp = 2'bxx;
      ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
      for (int i = 0; i < 20 && !hs; i++) begin
         @(negedge ACLK);
         hs = ARREADY;
         @(posedge ACLK); #1;
      end
      ARVALID = 1'b0;
      for (int i = 0; i < 20 && hs && !ok; i++) begin
         @(negedge ACLK);
         if (RVALID) begin
            d = RDATA; resp = RRESP; ok = 1'b1;
         end
         @(posedge ACLK); #1;
      end
      RREADY = 1'b0;
   endtask

   task automatic test_reset;
      #12;
      @(negedge ACLK);
      n_cmp++;
      if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_hs: got %b want 00000",
                  {AWREADY, WREADY, ARREADY, BVALID, RVALID});
      end
      n_cmp++;
      if ({leds, seg_anode, seg_cathode, irq_out} !== {4'h0, 4'hF, 7'h7F, 1'b0}) begin
         n_err++;
         $display("FAIL reset_out: got %h/%h/%h/%b want 0/f/7f/0",
                  leds, seg_anode, seg_cathode, irq_out);
      end
      n_cmp++;
      if ({RDATA, RRESP, BRESP} !== 36'h0) begin
         n_err++;
         $display("FAIL reset_data: got %h %b %b want 0", RDATA, RRESP, BRESP);
      end
      @(posedge ACLK); #1;
      ARESETn = 1'b1;
      @(negedge ACLK);
      n_cmp++;
      if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
         n_err++;
         $display("FAIL ready_pre: got %b want 000", {AWREADY, WREADY, ARREADY});
      end
      @(negedge ACLK);
      n_cmp++;
      if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
         n_err++;
         $display("FAIL ready_post: got %b want 111", {AWREADY, WREADY, ARREADY});
      end
      @(posedge ACLK); #1;
   endtask

   task automatic test_led;
      logic [1:0] r; logic ok; logic [31:0] d;
      axi_write(32'h0, 32'h0000_0005, 4'hF, r, ok);
      n_cmp++;
      if ({ok, r, leds} !== {1'b1, 2'b00, 4'b0101}) begin
         n_err++;
         $display("FAIL led_wr: got ok=%b resp=%b leds=%b want 1 00 0101", ok, r, leds);
      end
      axi_read(32'h0, d, r, ok);
      n_cmp++;
      if ({ok, r, d} !== {1'b1, 2'b00, 32'h5}) begin
         n_err++;
         $display("FAIL led_rd: got ok=%b resp=%b data=%h want 1 00 5", ok, r, d);
      end
      axi_write(32'h0, 32'h0000_000A, 4'h0, r, ok);
      n_cmp++;
      if ({ok, r, leds} !== {1'b1, 2'b00, 4'b0101}) begin
         n_err++;
         $display("FAIL led_nostrb: got ok=%b resp=%b leds=%b want 1 00 0101", ok, r, leds);
      end
   endtask

   task automatic test_split_write;
      logic got; logic stable;
      @(posedge ACLK); #1;
      AWADDR = 32'h0; AWVALID = 1'b1; BREADY = 1'b0;
      @(negedge ACLK);
      n_cmp++;
      if (AWREADY !== 1'b1) begin
         n_err++;
         $display("FAIL split_awrdy: got %b want 1", AWREADY);
      end
      @(posedge ACLK); #1;
      AWVALID = 1'b0;
      @(posedge ACLK); #1;
      @(negedge ACLK);
      n_cmp++;
      if ({AWREADY, WREADY, BVALID} !== 3'b010) begin
         n_err++;
         $display("FAIL split_held: got %b want 010", {AWREADY, WREADY, BVALID});
      end
      @(posedge ACLK); #1;
      WDATA = 32'h3; WSTRB = 4'hF; WVALID = 1'b1;
      @(posedge ACLK); #1;
      WVALID = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 4 && !got; i++) begin
         @(negedge ACLK);
         got = BVALID;
         if (!got) begin @(posedge ACLK); #1; end
      end
      n_cmp++;
      if (got !== 1'b1) begin
         n_err++;
         $display("FAIL split_bvalid: got %b want 1", got);
      end
      stable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge ACLK); #1;
         @(negedge ACLK);
         if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b10000) stable = 1'b0;
      end
      n_cmp++;
      if (stable !== 1'b1 || leds !== 4'h3) begin
         n_err++;
         $display("FAIL split_hold: got stable=%b leds=%h want 1 3", stable, leds);
      end
      @(posedge ACLK); #1;
      BREADY = 1'b1;
      @(posedge ACLK); #1;
      BREADY = 1'b0;
      @(negedge ACLK);
      n_cmp++;
      if ({BVALID, AWREADY, WREADY, leds} !== {3'b011, 4'h3}) begin
         n_err++;
         $display("FAIL split_done: got %b %h want 011 3", {BVALID, AWREADY, WREADY}, leds);
      end
   endtask

   task automatic test_back_to_back;
      logic got; logic [1:0] r; logic ok; logic [31:0] d;
      @(posedge ACLK); #1;
      AWADDR = 32'h0; AWVALID = 1'b1;
      WDATA = 32'h6; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
      @(posedge ACLK); #1;
      AWVALID = 1'b0; WVALID = 1'b0;
      @(negedge ACLK);
      n_cmp++;
      if (BVALID !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_early: got %b want 0", BVALID);
      end
      got = 1'b0;
      for (int i = 0; i < 2 && !got; i++) begin
         @(posedge ACLK); #1;
         @(negedge ACLK);
         got = BVALID;
      end
      n_cmp++;
      if ({got, BRESP, leds} !== {3'b100, 4'h6}) begin
         n_err++;
         $display("FAIL b2b_first: got %b %b %h want 1 00 6", got, BRESP, leds);
      end
      @(posedge ACLK); #1;
      BREADY = 1'b0;
      axi_write(32'h0, 32'hFFFF_FF0C, 4'h1, r, ok);
      axi_read(32'h0, d, r, ok);
      n_cmp++;
      if ({ok, r, d} !== {1'b1, 2'b00, 32'hC}) begin
         n_err++;
         $display("FAIL b2b_second: got %b %b %h want 1 00 c", ok, r, d);
      end
   endtask

   task automatic test_seg;
      logic [1:0] r; logic ok; logic [31:0] d; logic got;
      logic [3:0] an_exp [3];
      logic [6:0] ca_exp [3];
      an_exp = '{4'b1101, 4'b1011, 4'b0111};
      ca_exp = '{7'b0110000, 7'b0100100, 7'b1111001};
      axi_write(32'h4, 32'h0000_1234, 4'hF, r, ok);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge ACLK);
         got = (seg_anode !== 4'b1110);
      end
      for (int i = 0; i < 40 && got; i++) begin
         @(negedge ACLK);
         if (seg_anode === 4'b1110) break;
         if (i == 39) got = 1'b0;
      end
      n_cmp++;
      if ({got, seg_anode, seg_cathode} !== {1'b1, 4'b1110, 7'b0011001}) begin
         n_err++;
         $display("FAIL seg_d0: got %b an=%b ca=%b want 1 1110 0011001",
                  got, seg_anode, seg_cathode);
      end
      for (int k = 0; k < 3; k++) begin
         repeat (4) @(posedge ACLK);
         @(negedge ACLK);
         n_cmp++;
         if ({seg_anode, seg_cathode} !== {an_exp[k], ca_exp[k]}) begin
            n_err++;
            $display("FAIL seg_d%0d: got an=%b ca=%b want %b %b", k + 1,
                     seg_anode, seg_cathode, an_exp[k], ca_exp[k]);
         end
      end
      @(posedge ACLK); #1;
      axi_write(32'h4, 32'hFFFF_AB00, 4'b0010, r, ok);
      axi_read(32'h4, d, r, ok);
      n_cmp++;
      if ({ok, r, d} !== {1'b1, 2'b00, 32'h0000_AB34}) begin
         n_err++;
         $display("FAIL seg_strb: got %b %b %h want 1 00 0000ab34", ok, r, d);
      end
   endtask

   task automatic test_irq;
      logic [1:0] r; logic ok; logic [31:0] d; logic got;
      axi_write(32'h8, 32'h1, 4'hF, r, ok);
      @(posedge ACLK); #1;
      ext_irq_in = 1'b1;
      repeat (LAT) @(posedge ACLK);
      @(negedge ACLK);
      n_cmp++;
      if (irq_out !== 1'b0) begin
         n_err++;
         $display("FAIL irq_early: got %b want 0", irq_out);
      end
      @(posedge ACLK);
      @(negedge ACLK);
      n_cmp++;
      if (irq_out !== 1'b1) begin
         n_err++;
         $display("FAIL irq_lat: got %b want 1", irq_out);
      end
      @(posedge ACLK); #1;
      ext_irq_in = 1'b0;
      axi_read(32'hC, d, r, ok);
      n_cmp++;
      if ({ok, r, d} !== {1'b1, 2'b00, 32'h1}) begin
         n_err++;
         $display("FAIL irq_stat: got %b %b %h want 1 00 1", ok, r, d);
      end
      axi_write(32'hC, 32'h1, 4'hF, r, ok);
      @(posedge ACLK);
      @(negedge ACLK);
      n_cmp++;
      if ({ok, r, irq_out} !== 4'b1000) begin
         n_err++;
         $display("FAIL irq_clr: got %b %b %b want 1 00 0", ok, r, irq_out);
      end
      // Land the edge on the same edge as the W1C commit.
      BREADY = 1'b1;
      for (int t = 0; t < 3; t++) begin
         @(posedge ACLK); #1;
         if (t == 3 - LAT) ext_irq_in = 1'b1;
         if (t == 1) begin
            AWADDR = 32'hC; WDATA = 32'h1; WSTRB = 4'hF;
            AWVALID = 1'b1; WVALID = 1'b1;
         end
         if (t == 2) begin AWVALID = 1'b0; WVALID = 1'b0; end
      end
      got = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
         @(negedge ACLK);
         got = BVALID;
         @(posedge ACLK); #1;
      end
      BREADY = 1'b0;
      ext_irq_in = 1'b0;
      axi_read(32'hC, d, r, ok);
      n_cmp++;
      if ({got, ok, d} !== {2'b11, 32'h1}) begin
         n_err++;
         $display("FAIL irq_setwins: got %b %b %h want 1 1 1", got, ok, d);
      end
   endtask

   task automatic test_errors;
      logic [1:0] r; logic ok; logic [31:0] d;
      axi_read(32'h40, d, r, ok);
      n_cmp++;
      if ({ok, r, d} !== {1'b1, 2'b10, 32'h0}) begin
         n_err++;
         $display("FAIL err_rd40: got %b %b %h want 1 10 0", ok, r, d);
      end
      axi_read(32'h14, d, r, ok);
      n_cmp++;
      if ({ok, r, d} !== {1'b1, 2'b10, 32'h0}) begin
         n_err++;
         $display("FAIL err_rd14: got %b %b %h want 1 10 0", ok, r, d);
      end
      axi_read(32'h13, d, r, ok);
      n_cmp++;
      if ({ok, r, d} !== {1'b1, 2'b00, IDV}) begin
         n_err++;
         $display("FAIL id_rd13: got %b %b %h want 1 00 %h", ok, r, d, IDV);
      end
      axi_write(32'h10, 32'h0, 4'hF, r, ok);
      n_cmp++;
      if ({ok, r} !== 3'b110) begin
         n_err++;
         $display("FAIL err_wrid: got %b %b want 1 10", ok, r);
      end
      axi_read(32'h10, d, r, ok);
      n_cmp++;
      if ({ok, r, d} !== {1'b1, 2'b00, IDV}) begin
         n_err++;
         $display("FAIL id_keep: got %b %b %h want 1 00 %h", ok, r, d, IDV);
      end
      axi_write(32'h1000_0000, 32'h0, 4'hF, r, ok);
      n_cmp++;
      if ({ok, r, leds} !== {3'b110, 4'hC}) begin
         n_err++;
         $display("FAIL err_wrhi: got %b %b %h want 1 10 c", ok, r, leds);
      end
   endtask

   task automatic test_reset_mid;
      logic [1:0] r; logic ok; logic [31:0] d;
      @(posedge ACLK); #1;
      AWADDR = 32'h0; AWVALID = 1'b1;
      @(posedge ACLK); #1;
      @(posedge ACLK); #1;
      ARESETn = 1'b0;
      @(negedge ACLK);
      n_cmp++;
      if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, leds, seg_anode,
           seg_cathode, irq_out, RDATA} !== {5'b0, 4'h0, 4'hF, 7'h7F, 1'b0, 32'h0}) begin
         n_err++;
         $display("FAIL rstmid_out: got %b %h %h %h %b %h", {AWREADY, WREADY,
                  ARREADY, BVALID, RVALID}, leds, seg_anode, seg_cathode, irq_out, RDATA);
      end
      AWVALID = 1'b0;
      @(posedge ACLK); #1;
      ARESETn = 1'b1;
      repeat (2) @(posedge ACLK);
      #1;
      axi_write(32'h0, 32'h9, 4'hF, r, ok);
      n_cmp++;
      if ({ok, r, leds} !== {3'b100, 4'h9}) begin
         n_err++;
         $display("FAIL rstmid_wr: got %b %b %h want 1 00 9", ok, r, leds);
      end
      axi_read(32'h8, d, r, ok);
      n_cmp++;
      if ({ok, r, d} !== {3'b100, 32'h0}) begin
         n_err++;
         $display("FAIL rstmid_en: got %b %b %h want 1 00 0", ok, r, d);
      end
   endtask

   initial begin
      test_reset;
      test_led;
      test_split_write;
      test_back_to_back;
      test_seg;
      test_irq;
      test_errors;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
